crc32_scan_ctrl: RTL and testbench
==================================

CRC32_SCAN_CTRL -- requirements
Module: crc32_scan_ctrl

Interface
REQ-001 Parameter ADDR_W, default 25, memory byte-address width.
REQ-002 Parameter LEN_W, default 24, byte-count width.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-006 Port abort  in  1  terminate any active scan.
REQ-007 Port base_addr  in  ADDR_W  first byte address; latched on accepted start.
REQ-008 Port length  in  LEN_W  number of bytes; latched on accepted start.
REQ-009 Port expected_crc  in  32  reference value; latched on accepted start.
REQ-010 Port busy  out  1  high from the cycle after an accepted start until completion.
REQ-011 Port done  out  1  one-cycle completion pulse.
REQ-012 Port crc_result  out  32  final CRC-32; holds until next completion.
REQ-013 Port match  out  1  crc_result == latched expected_crc; updates with crc_result.
REQ-014 Port error  out  1  last scan ended by timeout; updates on done.
REQ-015 Port mem_rd / mem_addr  out  1 / ADDR_W  byte read request and address.
REQ-016 Port mem_ack / mem_data  in  1 / 8  read acknowledge; data valid in the ack cycle.
REQ-017 Port crc_en / crc_we / crc_data  out  1 / 1 / 8  control of the byte-wise CRC-32 engine.
REQ-018 Port crc_value  in  32  finalized engine output, registered on the first cycle crc_en is low after being high.

Function
REQ-019 FSM states: IDLE, REQ, FEED, FLUSH, CAPTURE, DONE.
REQ-020 IDLE: start=1, abort=0, length!=0 -> REQ; length==0 -> DONE with crc_result=0x00000000, engine untouched.
REQ-021 REQ: mem_rd=1, mem_addr stable, crc_en=1; on mem_ack=1 capture mem_data -> FEED.
REQ-022 FEED: crc_we=1 for exactly one cycle with the captured byte; address +1, remaining count -1; remaining==0 -> FLUSH, else -> REQ.
REQ-023 crc_en stays high continuously from entry to first REQ through the last FEED.
REQ-024 FLUSH: crc_en=0 for one cycle (engine finalizes); -> CAPTURE.
REQ-025 CAPTURE: crc_result<=crc_value, match<=(crc_value==expected), error<=0; -> DONE.
REQ-026 DONE: done=1, busy=0 for one cycle; -> IDLE.
REQ-027 Per-byte throughput: ack latency + 2 cycles; completion 2 cycles after last FEED, then done.
REQ-028 Address increments modulo 2^ADDR_W; wrap is not an error.
REQ-029 start while busy is ignored; start and abort together in IDLE: abort wins, start ignored.
REQ-030 abort in REQ/FEED/FLUSH/CAPTURE -> IDLE next cycle: mem_rd=0, crc_en=0, no done, crc_result/match/error unchanged.
REQ-031 mem_ack outside REQ is ignored.

Reset
REQ-032 reset -> IDLE; busy, done, mem_rd, crc_en, crc_we, match, error = 0; crc_result, mem_addr, crc_data = 0.
REQ-033 reset mid-scan abandons the scan with no done pulse; next start behaves as after power-up.

Configuration
REQ-034 Macro CRC32_SCAN_TIMEOUT_EN defined: 10-bit counter in REQ; 1024 cycles without mem_ack -> mem_rd=0, crc_en=0, -> DONE with error=1, match=0, crc_result unchanged.
REQ-035 Macro undefined: no counter; REQ waits indefinitely; error tied to 0.

Verification
REQ-036 Bytes 0x61 0x62 0x63, expected 0x352441C2 -> crc_result=0x352441C2, match=1, one done pulse.
REQ-037 ASCII "123456789", random ack latency 0-5 -> crc_result=0xCBF43926; exactly 9 crc_we pulses, crc_en never drops mid-scan.
REQ-038 length=0, expected 0 -> done 2 cycles after start, crc_result=0, match=1, mem_rd never asserted.
REQ-039 Single byte 0x00, expected 0 -> crc_result=0xD202EF8D, match=0; base_addr=2^ADDR_W-1, length=2 -> second read at address 0.
REQ-040 abort during byte 5 of 9, then "abc" scan -> no done for aborted scan, second result 0x352441C2.
REQ-041 With CRC32_SCAN_TIMEOUT_EN, mem_ack withheld -> done 1024+ cycles after mem_rd rises, error=1; without macro busy stays high.

Source files
------------

// File: rtl/crc32_scan_ctrl_if.sv
// Memory read port and byte-wise CRC-32 engine port shared by the scan controller
// (master) and the memory/engine side (slave).
interface crc32_scan_ctrl_if #(
    parameter int unsigned ADDR_W = 25
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic              crc_en;
    logic              crc_we;
    logic [7:0]        crc_data;
    logic [31:0]       crc_value;

    modport master (
        output mem_rd, mem_addr, crc_en, crc_we, crc_data,
        input  mem_ack, mem_data, crc_value
    );

    modport slave (
        input  mem_rd, mem_addr, crc_en, crc_we, crc_data,
        output mem_ack, mem_data, crc_value
    );
endinterface

// File: rtl/crc32_scan_ctrl.sv
// CRC-32 scan controller: reads a byte range, streams it into an external CRC-32 engine
// and compares the result. Define CRC32_SCAN_TIMEOUT_EN for a 1024-cycle read timeout.
module crc32_scan_ctrl #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned LEN_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [31:0]       expected_crc,
    output logic              busy,
    output logic              done,
    output logic [31:0]       crc_result,
    output logic              match,
    output logic              error,
    crc32_scan_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StFeed,
        StFlush,
        StCapture,
        StDone
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [31:0]       expected_q;
    logic              mem_rd_q;
    logic              crc_en_q;
    logic              crc_we_q;
    logic [7:0]        crc_data_q;

`ifdef CRC32_SCAN_TIMEOUT_EN
    logic [9:0]        tmo_q;
    logic              error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = addr_q;
    assign bus.crc_en   = crc_en_q;
    assign bus.crc_we   = crc_we_q;
    assign bus.crc_data = crc_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            expected_q  <= '0;
            mem_rd_q    <= 1'b0;
            crc_en_q    <= 1'b0;
            crc_we_q    <= 1'b0;
            crc_data_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            crc_result  <= '0;
            match       <= 1'b0;
`ifdef CRC32_SCAN_TIMEOUT_EN
            tmo_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            crc_we_q <= 1'b0;
`ifdef CRC32_SCAN_TIMEOUT_EN
            // The timeout window restarts on every entry into StReq.
            if (state_q != StReq) begin
                tmo_q <= '0;
            end
`endif
            if (abort && (state_q inside {StReq, StFeed, StFlush, StCapture})) begin
                // Abandon silently: results from the previous scan stay visible.
                state_q  <= StIdle;
                mem_rd_q <= 1'b0;
                crc_en_q <= 1'b0;
                busy     <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            addr_q      <= base_addr;
                            remaining_q <= length;
                            expected_q  <= expected_crc;
                            if (length == '0) begin
                                crc_result <= '0;
                                match      <= (expected_crc == 32'h0000_0000);
`ifdef CRC32_SCAN_TIMEOUT_EN
                                error_q    <= 1'b0;
`endif
                                done       <= 1'b1;
                                state_q    <= StDone;
                            end else begin
                                mem_rd_q <= 1'b1;
                                crc_en_q <= 1'b1;
                                busy     <= 1'b1;
                                state_q  <= StReq;
                            end
                        end
                    end
                    StReq: begin
                        if (bus.mem_ack) begin
                            mem_rd_q   <= 1'b0;
                            crc_data_q <= bus.mem_data;
                            crc_we_q   <= 1'b1;
                            state_q    <= StFeed;
                        end
`ifdef CRC32_SCAN_TIMEOUT_EN
                        else if (tmo_q == 10'h3ff) begin
                            mem_rd_q <= 1'b0;
                            crc_en_q <= 1'b0;
                            busy     <= 1'b0;
                            match    <= 1'b0;
                            error_q  <= 1'b1;
                            done     <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            tmo_q <= tmo_q + 10'd1;
                        end
`endif
                    end
                    StFeed: begin
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            // Dropping crc_en tells the engine to finalize.
                            crc_en_q <= 1'b0;
                            state_q  <= StFlush;
                        end else begin
                            mem_rd_q <= 1'b1;
                            state_q  <= StReq;
                        end
                    end
                    StFlush: begin
                        state_q <= StCapture;
                    end
                    StCapture: begin
                        crc_result <= bus.crc_value;
                        match      <= (bus.crc_value == expected_q);
`ifdef CRC32_SCAN_TIMEOUT_EN
                        error_q    <= 1'b0;
`endif
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state_q    <= StDone;
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc32_scan_ctrl.sv
// Self-checking bench for crc32_scan_ctrl: behavioural memory with random ack latency,
// behavioural byte-wise CRC-32 engine, and a whole-message CRC-32 reference model.
module tb_crc32_scan_ctrl;
    localparam int unsigned ADDR_W = 25;
    localparam int unsigned LEN_W  = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic [31:0]       expected_crc;
    logic              busy;
    logic              done;
    logic [31:0]       crc_result;
    logic              match;
    logic              error;

    crc32_scan_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    crc32_scan_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .length       (length),
        .expected_crc (expected_crc),
        .busy         (busy),
        .done         (done),
        .crc_result   (crc_result),
        .match        (match),
        .error        (error),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: CRC-32 (reflected, init all-ones, final invert) over a whole message.
    function automatic logic [31:0] crc32_ref(input logic [7:0] d [$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Engine: starts on crc_en rising, folds bytes on crc_we, publishes when crc_en falls.
    logic [31:0] eng_acc;
    logic        eng_en_q;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_acc       <= 32'h0;
            eng_en_q      <= 1'b0;
            bus.crc_value <= 32'h0;
        end else begin
            if (bus.crc_en) begin
                if (bus.crc_we)
                    eng_acc <= crc_step(eng_en_q ? eng_acc : 32'hFFFF_FFFF, bus.crc_data);
                else
                    eng_acc <= eng_en_q ? eng_acc : 32'hFFFF_FFFF;
            end else if (eng_en_q) begin
                bus.crc_value <= ~eng_acc;
            end
            eng_en_q <= bus.crc_en;
        end
    end

    // Memory responder with random latency and optional stray acks outside requests.
    logic [7:0]        mem [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] addr_q [$];
    int max_lat = 0;
    int lat_cnt = 0;
    int lat_tgt = 0;
    bit ack_en = 1'b1;
    bit stray_en = 1'b0;
    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (bus.mem_rd && ack_en) begin
            if (lat_cnt >= lat_tgt) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 8'h00;
                addr_q.push_back(bus.mem_addr);
                lat_cnt = 0;
                lat_tgt = $urandom_range(max_lat, 0);
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
            if (stray_en && !bus.mem_rd && ($urandom_range(1, 0) == 1)) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = 8'($urandom);
            end
        end
    end

    // Activity monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int we_cnt, done_cnt, en_falls, rd_cycles, en_cycles, last_we_cyc, done_cyc;
    logic [7:0] fed_q [$];
    logic en_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.crc_we) begin
            we_cnt++;
            fed_q.push_back(bus.crc_data);
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (en_prev && !bus.crc_en) en_falls++;
        if (bus.mem_rd) rd_cycles++;
        if (bus.crc_en) en_cycles++;
        en_prev = bus.crc_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        addr_q.delete();
        fed_q.delete();
        we_cnt = 0; done_cnt = 0; en_falls = 0; rd_cycles = 0; en_cycles = 0;
        last_we_cyc = 0; done_cyc = 0;
    endtask

    logic [7:0] scan_bytes [$];
    bit         scan_timeout;
    bit         busy_after_start;
    int         start_cyc;

    task automatic load_mem(input logic [ADDR_W-1:0] base);
        foreach (scan_bytes[i]) mem[ADDR_W'(base + ADDR_W'(i))] = scan_bytes[i];
    endtask

    // Launch a scan of scan_bytes and wait (bounded) for done; poke>=0 re-pulses start mid-scan.
    task automatic run_scan(input logic [ADDR_W-1:0] base, input logic [31:0] exp,
                            input int budget, input int poke);
        load_mem(base);
        clear_mon();
        base_addr    = base;
        length       = LEN_W'(scan_bytes.size());
        expected_crc = exp;
        start        = 1'b1;
        tick();
        start            = 1'b0;
        start_cyc        = cyc;
        busy_after_start = busy;
        scan_timeout     = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                scan_timeout = 1'b0;
                break;
            end
            start = (i == poke);
            if (i == poke) begin
                base_addr    = ~base;
                length       = LEN_W'(1);
                expected_crc = ~exp;
            end
            tick();
        end
        start = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, match, error, bus.mem_rd, bus.crc_en, bus.crc_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000000",
                     {busy, done, match, error, bus.mem_rd, bus.crc_en, bus.crc_we});
        end
        checks++;
        if ({crc_result, bus.mem_addr, bus.crc_data} !== '0) begin
            errors++;
            $display("FAIL reset_values result=%h addr=%h data=%h want 0",
                     crc_result, bus.mem_addr, bus.crc_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_abc();
        logic [ADDR_W-1:0] base;
        bit bad;
        base = ADDR_W'($urandom);
        scan_bytes = '{8'h61, 8'h62, 8'h63};
        max_lat = 2;
        run_scan(base, 32'h3524_41C2, 200, -1);
        checks++;
        if (scan_timeout) begin errors++; $display("FAIL abc_done timed out"); end
        checks++;
        if (crc_result !== 32'h3524_41C2 || match !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL abc_result got %h m=%b e=%b want 352441c2 m=1 e=0",
                     crc_result, match, error);
        end
        checks++;
        if (done_cnt !== 1 || we_cnt !== 3 || busy_after_start !== 1'b1) begin
            errors++;
            $display("FAIL abc_pulses done=%0d we=%0d busy=%b want 1 3 1",
                     done_cnt, we_cnt, busy_after_start);
        end
        checks++;
        if (done_cyc - last_we_cyc !== 3) begin
            errors++;
            $display("FAIL abc_latency got %0d want 3", done_cyc - last_we_cyc);
        end
        bad = (addr_q.size() != 3);
        foreach (addr_q[i]) if (addr_q[i] !== ADDR_W'(base + ADDR_W'(i))) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL abc_addr got %p from base %h", addr_q, base); end
    endtask

    task automatic test_check_string();
        bit bad;
        scan_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        max_lat = 5;
        stray_en = 1'b1;
        run_scan(ADDR_W'(32'h100), 32'hCBF4_3926, 400, -1);
        stray_en = 1'b0;
        checks++;
        if (scan_timeout || crc_result !== 32'hCBF4_3926 || match !== 1'b1) begin
            errors++;
            $display("FAIL check_result got %h m=%b to=%b want cbf43926 m=1",
                     crc_result, match, scan_timeout);
        end
        checks++;
        if (we_cnt !== 9 || en_falls !== 1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL check_pulses we=%0d en_falls=%0d done=%0d want 9 1 1",
                     we_cnt, en_falls, done_cnt);
        end
        bad = (fed_q.size() != 9);
        foreach (fed_q[i]) if (fed_q[i] !== scan_bytes[i]) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL check_bytes got %p", fed_q); end
    endtask

    task automatic test_zero_length();
        int lat;
        scan_bytes.delete();
        run_scan(ADDR_W'(32'h40), 32'h0, 10, -1);
        lat = done_cyc - (start_cyc - 1);
        checks++;
        if (scan_timeout || lat < 1 || lat > 2 || done_cnt !== 1) begin
            errors++;
            $display("FAIL zero_done latency=%0d count=%0d want <=2 and 1", lat, done_cnt);
        end
        checks++;
        if (crc_result !== 32'h0 || match !== 1'b1 || rd_cycles !== 0 || en_cycles !== 0) begin
            errors++;
            $display("FAIL zero_result got %h m=%b rd=%0d en=%0d want 0 1 0 0",
                     crc_result, match, rd_cycles, en_cycles);
        end
    endtask

    task automatic test_single_and_wrap();
        logic [31:0] r;
        max_lat = 1;
        scan_bytes = '{8'h00};
        run_scan(ADDR_W'(32'h7), 32'h0, 100, -1);
        checks++;
        if (scan_timeout || crc_result !== 32'hD202_EF8D || match !== 1'b0) begin
            errors++;
            $display("FAIL single_result got %h m=%b want d202ef8d m=0", crc_result, match);
        end
        scan_bytes = '{8'($urandom), 8'($urandom)};
        r = crc32_ref(scan_bytes);
        run_scan('1, r, 100, -1);
        checks++;
        if (addr_q.size() != 2 || addr_q[0] !== '1 || addr_q[1] !== '0) begin
            errors++;
            $display("FAIL wrap_addr got %p want 1ffffff then 0", addr_q);
        end
        checks++;
        if (crc_result !== r || match !== 1'b1) begin
            errors++;
            $display("FAIL wrap_result got %h m=%b want %h m=1", crc_result, match, r);
        end
    endtask

    task automatic test_abort();
        bit hit;
        max_lat = 0;
        scan_bytes = '{8'h00};
        run_scan(ADDR_W'(32'h10), 32'h0, 100, -1);
        max_lat = 3;
        scan_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        load_mem(ADDR_W'(32'h200));
        clear_mon();
        base_addr = ADDR_W'(32'h200); length = LEN_W'(9); expected_crc = 32'hCBF4_3926;
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (we_cnt == 4 && bus.mem_rd) begin hit = 1'b1; break; end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (!hit || bus.mem_rd !== 1'b0 || bus.crc_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle hit=%b rd=%b en=%b busy=%b want 1 0 0 0",
                     hit, bus.mem_rd, bus.crc_en, busy);
        end
        repeat (20) tick();
        checks++;
        if (done_cnt !== 0 || crc_result !== 32'hD202_EF8D || match !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold done=%0d result=%h m=%b want 0 d202ef8d 0",
                     done_cnt, crc_result, match);
        end
        scan_bytes = '{8'h61, 8'h62, 8'h63};
        run_scan(ADDR_W'(32'h300), 32'h3524_41C2, 200, -1);
        checks++;
        if (scan_timeout || crc_result !== 32'h3524_41C2 || match !== 1'b1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL abort_next got %h m=%b done=%0d want 352441c2 1 1",
                     crc_result, match, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        max_lat = 2;
        scan_bytes = '{8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h3C, 8'hC3};
        r = crc32_ref(scan_bytes);
        run_scan(ADDR_W'(32'h500), r, 300, 4);
        checks++;
        if (scan_timeout || crc_result !== r || match !== 1'b1 || we_cnt !== 6 || done_cnt !== 1) begin
            errors++;
            $display("FAIL busy_start got %h m=%b we=%0d done=%0d want %h 1 6 1",
                     crc_result, match, we_cnt, done_cnt, r);
        end
        clear_mon();
        start = 1'b1; abort = 1'b1; length = LEN_W'(3);
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (5) tick();
        checks++;
        if (rd_cycles !== 0 || done_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort rd=%0d done=%0d busy=%b want 0 0 0",
                     rd_cycles, done_cnt, busy);
        end
    endtask

    task automatic test_random();
        logic [31:0]       r, exp;
        logic [ADDR_W-1:0] base;
        int                n;
        bit                bad;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(12, 1);
            base = ADDR_W'($urandom);
            scan_bytes.delete();
            for (int k = 0; k < n; k++) scan_bytes.push_back(8'($urandom));
            r = crc32_ref(scan_bytes);
            exp = ($urandom_range(1, 0) == 1) ? r : $urandom;
            max_lat = $urandom_range(3, 0);
            run_scan(base, exp, 500, -1);
            checks++;
            if (scan_timeout || crc_result !== r || match !== (exp == r) || done_cnt !== 1) begin
                errors++;
                $display("FAIL random_%0d got %h m=%b done=%0d want %h m=%b 1",
                         t, crc_result, match, done_cnt, r, (exp == r));
            end
            bad = (addr_q.size() != n) || (fed_q.size() != n);
            foreach (addr_q[i]) if (addr_q[i] !== ADDR_W'(base + ADDR_W'(i))) bad = 1'b1;
            foreach (fed_q[i]) if (fed_q[i] !== scan_bytes[i]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL random_stream_%0d addrs=%0d bytes=%0d want %0d",
                         t, addr_q.size(), fed_q.size(), n);
            end
        end
    endtask

    task automatic test_reset_midscan();
        bit hit;
        max_lat = 1;
        scan_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load_mem(ADDR_W'(32'h800));
        clear_mon();
        base_addr = ADDR_W'(32'h800); length = LEN_W'(8); expected_crc = 32'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (we_cnt == 3) begin hit = 1'b1; break; end
            tick();
        end
        reset = 1'b1;
        tick();
        checks++;
        if (!hit || {busy, done, match, bus.mem_rd, bus.crc_en} !== 5'b0 || crc_result !== 32'h0) begin
            errors++;
            $display("FAIL midscan_reset hit=%b flags=%b result=%h want 1 00000 0",
                     hit, {busy, done, match, bus.mem_rd, bus.crc_en}, crc_result);
        end
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL midscan_done got %0d want 0", done_cnt); end
        scan_bytes = '{8'h61, 8'h62, 8'h63};
        run_scan(ADDR_W'(32'h900), 32'h3524_41C2, 200, -1);
        checks++;
        if (scan_timeout || crc_result !== 32'h3524_41C2 || match !== 1'b1) begin
            errors++;
            $display("FAIL midscan_next got %h m=%b want 352441c2 1", crc_result, match);
        end
    endtask

    task automatic test_timeout();
        scan_bytes = '{8'h61, 8'h62, 8'h63};
        run_scan(ADDR_W'(32'hA00), 32'h3524_41C2, 200, -1);
        ack_en = 1'b0;
        scan_bytes = '{8'h01, 8'h02, 8'h03};
`ifdef CRC32_SCAN_TIMEOUT_EN
        run_scan(ADDR_W'(32'hB00), 32'h0, 1100, -1);
        checks++;
        if (scan_timeout || done_cyc - start_cyc < 1024 || done_cyc - start_cyc > 1030) begin
            errors++;
            $display("FAIL timeout_done to=%b cycles=%0d want 1024..1030",
                     scan_timeout, done_cyc - start_cyc);
        end
        checks++;
        if (error !== 1'b1 || match !== 1'b0 || crc_result !== 32'h3524_41C2 || bus.mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags e=%b m=%b result=%h rd=%b want 1 0 352441c2 0",
                     error, match, crc_result, bus.mem_rd);
        end
        ack_en = 1'b1;
        scan_bytes = '{8'h00};
        run_scan(ADDR_W'(32'hC00), 32'h0, 100, -1);
        checks++;
        if (error !== 1'b0 || crc_result !== 32'hD202_EF8D) begin
            errors++;
            $display("FAIL timeout_clear e=%b result=%h want 0 d202ef8d", error, crc_result);
        end
`else
        run_scan(ADDR_W'(32'hB00), 32'h0, 1100, -1);
        checks++;
        if (!scan_timeout || busy !== 1'b1 || done_cnt !== 0 || error !== 1'b0) begin
            errors++;
            $display("FAIL nowait_hold busy=%b done=%0d e=%b want 1 0 0", busy, done_cnt, error);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ack_en = 1'b1;
        checks++;
        if (busy !== 1'b0 || crc_result !== 32'h3524_41C2) begin
            errors++;
            $display("FAIL nowait_abort busy=%b result=%h want 0 352441c2", busy, crc_result);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0; expected_crc = '0;
        clear_mon();
        test_reset();
        test_abc();
        test_check_string();
        test_zero_length();
        test_single_and_wrap();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_midscan();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
